// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the TX stage, with the RX stage to follow.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   // 100 MHz system clock / 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1, ticks on the terminal count
// and wraps. A synchronous clear holds it at zero so a new bit starts aligned.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // count up, wrap to zero at the terminal count
   always_ff @(posedge clk) begin
      if (rst || clr || tick) cnt <= '0;
      else                    cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == TERM);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining the TX FIFO: start bit, data LSB first,
// optional parity, one or two stop bits. The line is driven from a flop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_read_data,
   output logic                  fifo_read_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic LAST_STOP = (STOP_BITS == 2);
   localparam parity_e PAR_MODE = parity_e'(2'(PARITY));

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  stop_q, stop_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  tick;
   logic                  clr;

   // the bit period restarts from zero for every frame
   assign clr = (state_q == IDLE) || (state_q == FETCH);

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   // next-state, datapath updates and the value the line takes next cycle
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_d        = bit_q;
      stop_d       = stop_q;
      par_d        = par_q;
      fifo_read_en = 1'b0;
      done         = 1'b0;
      case (state_q)
         IDLE: begin
            fifo_read_en = !rst && tx_en && !fifo_empty;
            if (fifo_read_en) state_d = FETCH;
         end
         FETCH: begin
            // read_data is valid now, one cycle after the pop
            shift_d = fifo_read_data;
            par_d   = (PAR_MODE == PAR_ODD) ? ~^fifo_read_data : ^fifo_read_data;
            bit_d   = '0;
            stop_d  = 1'b0;
            state_d = START;
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  state_d = (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         uart_pkg::PARITY: begin
            if (tick) state_d = STOP;
         end
         STOP: begin
            if (tick) begin
               if (stop_q == LAST_STOP) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:            tx_d = 1'b0;
         DATA:             tx_d = shift_d[0];
         uart_pkg::PARITY: tx_d = par_d;
         default:          tx_d = 1'b1;
      endcase
   end

   // state and datapath registers; reset abandons any partial frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity/1 stop, even/1 stop,
// odd/2 stops) at 4 clocks per bit, each fed by a behavioural FIFO.
module tb_uart_tx;

   localparam int CPB = 4;

   typedef struct {
      int          inst;
      logic [7:0]  data;
      logic [11:0] pat;   // expected line value per bit period, bit 0 first
      int          nb;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] en, hold, rd_w, tx_w, busy_w, done_w;
   logic [2:0] fe = 3'b111;
   logic [7:0] rdata [3];
   logic [7:0] fq [3][$];
   int         cyc = 0;
   int         pops [3];
   int         pop_cyc [3];
   int         bad_pop = 0;
   int         nerr = 0, nchk = 0;

   always #5 clk = ~clk;

   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .tx_en(en[0]), .fifo_empty(fe[0] | hold[0]),
      .fifo_read_data(rdata[0]), .fifo_read_en(rd_w[0]), .tx(tx_w[0]),
      .busy(busy_w[0]), .done(done_w[0]));

   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_b (
      .clk(clk), .rst(rst), .tx_en(en[1]), .fifo_empty(fe[1] | hold[1]),
      .fifo_read_data(rdata[1]), .fifo_read_en(rd_w[1]), .tx(tx_w[1]),
      .busy(busy_w[1]), .done(done_w[1]));

   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u_c (
      .clk(clk), .rst(rst), .tx_en(en[2]), .fifo_empty(fe[2] | hold[2]),
      .fifo_read_data(rdata[2]), .fifo_read_en(rd_w[2]), .tx(tx_w[2]),
      .busy(busy_w[2]), .done(done_w[2]));

   always @(posedge clk) cyc <= cyc + 1;

   // behavioural FIFO: registered read data, empty flag updated at the edge
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rd_w[i] === 1'b1) begin
            pops[i]++;
            pop_cyc[i] = cyc;
            if (fe[i] | hold[i]) bad_pop++;
            if (fq[i].size() != 0) rdata[i] <= fq[i].pop_front();
         end
         fe[i] <= (fq[i].size() == 0);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int i, input logic [7:0] d);
      fq[i].push_back(d);
   endtask

   // reference frame: start 0, data LSB first, parity from the ones count, stop 1s
   function automatic void ref_pat(input logic [7:0] d, input int par, input int stops,
                                   output logic [11:0] pat, output int nb);
      int k;
      pat = '1;
      pat[0] = 1'b0;
      for (int b = 0; b < 8; b++) pat[1 + b] = d[b];
      k = 9;
      if (par != 0) begin
         pat[k] = ($countones(d) % 2 == 1) ? (par == 1) : (par == 2);
         k++;
      end
      nb = k + stops;
   endfunction

   // wait for a start bit, then compare every cycle of the frame to pat
   task automatic run_frame(input int i, input logic [11:0] pat, input int nb,
                            output int st, output int dc);
      int t, len, bad, dbad, bbad;
      t = 0;
      while (tx_w[i] !== 1'b0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("start_seen", int'(tx_w[i] === 1'b0), 1);
      st = cyc;
      chk("pop_to_start", st - pop_cyc[i], 2);
      len = nb * CPB;
      bad = 0; dbad = 0; bbad = 0; dc = cyc;
      for (int c = 0; c < len; c++) begin
         if (tx_w[i] !== pat[c / CPB]) bad++;
         if (done_w[i] !== (c == len - 1)) dbad++;
         if (busy_w[i] !== 1'b1) bbad++;
         dc = cyc;
         @(negedge clk);
      end
      chk("frame_bits", bad, 0);
      chk("done_pulse", dbad, 0);
      chk("busy_in_frame", bbad, 0);
      chk("busy_after_done", int'(busy_w[i] !== 1'b0), 0);
   endtask

   initial begin
      vec_t        tbl [9];
      logic [11:0] pat;
      int          nb, st, dc, st2, dc2, p0, lowc, rdc, busyc, inst, r;
      logic [7:0]  d;

      tbl[0] = '{0, 8'h55, 12'b001010101010, 10};
      tbl[1] = '{0, 8'hA3, 12'b001101000110, 10};
      tbl[2] = '{0, 8'h0F, 12'b001000011110, 10};
      tbl[3] = '{0, 8'h3C, 12'b001001111000, 10};
      tbl[4] = '{1, 8'h07, 12'b011000001110, 11};
      tbl[5] = '{2, 8'h07, 12'b110000001110, 12};
      tbl[6] = '{1, 8'hFF, 12'b010111111110, 11};
      tbl[7] = '{2, 8'h00, 12'b111000000000, 12};
      tbl[8] = '{0, 8'h11, 12'b001000100010, 10};

      for (int i = 0; i < 3; i++) begin
         pops[i] = 0;
         pop_cyc[i] = 0;
         rdata[i] = 8'h00;
      end
      rst = 1'b1; en = 3'b000; hold = 3'b000;
      repeat (3) @(negedge clk);
      chk("reset_tx", int'(tx_w), 7);
      chk("reset_busy", int'(busy_w), 0);
      chk("reset_done", int'(done_w), 0);
      chk("reset_read_en", int'(rd_w), 0);
      rst = 1'b0;
      @(negedge clk);

      // table-driven single frames across all three configurations
      for (int v = 0; v < 9; v++) begin
         push(tbl[v].inst, tbl[v].data);
         en[tbl[v].inst] = 1'b1;
         run_frame(tbl[v].inst, tbl[v].pat, tbl[v].nb, st, dc);
         en[tbl[v].inst] = 1'b0;
         repeat (2) @(negedge clk);
      end
      chk("table_pops_a", pops[0], 5);

      // back-to-back: exactly two idle-high cycles between frames
      push(0, 8'hA3); push(0, 8'h0F);
      en[0] = 1'b1;
      run_frame(0, 12'b001101000110, 10, st, dc);
      run_frame(0, 12'b001000011110, 10, st2, dc2);
      chk("b2b_gap", st2 - dc, 3);
      en[0] = 1'b0;

      // empty FIFO with enable: no pop, line idle
      en[0] = 1'b1;
      p0 = pops[0]; lowc = 0; rdc = 0; busyc = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1) lowc++;
         if (rd_w[0] !== 1'b0) rdc++;
         if (busy_w[0] !== 1'b0) busyc++;
      end
      chk("empty_tx_low", lowc, 0);
      chk("empty_read_en", rdc, 0);
      chk("empty_busy", busyc, 0);
      en[0] = 1'b0;

      // data present but disabled: no pop until enabled
      push(0, 8'h5A);
      p0 = pops[0]; lowc = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1) lowc++;
      end
      chk("disabled_pops", pops[0] - p0, 0);
      chk("disabled_tx_low", lowc, 0);
      en[0] = 1'b1;
      ref_pat(8'h5A, 0, 1, pat, nb);
      run_frame(0, pat, nb, st, dc);
      en[0] = 1'b0;

      // tx_en dropped mid-frame: frame completes, nothing further popped
      push(0, 8'h81); push(0, 8'h42);
      p0 = pops[0];
      en[0] = 1'b1;
      ref_pat(8'h81, 0, 1, pat, nb);
      fork
         run_frame(0, pat, nb, st, dc);
         begin
            repeat (8) @(negedge clk);
            en[0] = 1'b0;
         end
      join
      lowc = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1) lowc++;
      end
      chk("en_drop_pops", pops[0] - p0, 1);
      chk("en_drop_tx_low", lowc, 0);
      en[0] = 1'b1;
      ref_pat(8'h42, 0, 1, pat, nb);
      run_frame(0, pat, nb, st, dc);

      // empty flag toggling mid-frame is ignored
      push(0, 8'h66);
      ref_pat(8'h66, 0, 1, pat, nb);
      fork
         run_frame(0, pat, nb, st, dc);
         begin
            repeat (6) @(negedge clk);
            hold[0] = 1'b1;
            repeat (10) @(negedge clk);
            hold[0] = 1'b0;
         end
      join
      en[0] = 1'b0;

      // reset during data bit 3, then a clean 0x3C frame
      push(0, 8'hF0);
      en[0] = 1'b1;
      r = 0;
      while (tx_w[0] !== 1'b0 && r < 400) begin
         @(negedge clk);
         r++;
      end
      chk("rst_frame_start", int'(tx_w[0] === 1'b0), 1);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx", int'(tx_w[0] === 1'b1), 1);
      chk("midrst_busy", int'(busy_w[0] === 1'b0), 1);
      chk("midrst_read_en", int'(rd_w[0] === 1'b0), 1);
      rst = 1'b0;
      push(0, 8'h3C);
      run_frame(0, 12'b001001111000, 10, st, dc);
      en[0] = 1'b0;

      // four queued bytes drain in order, back to back, then empty
      p0 = pops[0];
      push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
      @(negedge clk);
      chk("fifo4_not_empty", int'(fe[0]), 0);
      en[0] = 1'b1;
      dc2 = 0;
      for (int k = 0; k < 4; k++) begin
         d = 8'(8'h11 * (k + 1));
         ref_pat(d, 0, 1, pat, nb);
         run_frame(0, pat, nb, st, dc);
         if (k > 0) chk("fifo4_gap", st - dc2, 3);
         dc2 = dc;
      end
      chk("fifo4_pops", pops[0] - p0, 4);
      chk("fifo4_empty", int'(fe[0]), 1);
      en[0] = 1'b0;

      // randomized frames against the reference model
      for (int n = 0; n < 24; n++) begin
         inst = $urandom_range(0, 2);
         d = 8'($urandom);
         r = $urandom_range(0, 5);
         hold[inst] = 1'b1;
         push(inst, d);
         en[inst] = 1'b1;
         repeat (r) @(negedge clk);
         hold[inst] = 1'b0;
         ref_pat(d, inst, (inst == 2) ? 2 : 1, pat, nb);
         run_frame(inst, pat, nb, st, dc);
         en[inst] = 1'b0;
         @(negedge clk);
      end

      chk("no_pop_while_empty", bad_pop, 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that drains the TX FIFO. It pops one byte at a time through the FIFO read port (`read_en` / registered `read_data` / `empty`) and shifts it out on `tx` as a start bit, data bits LSB first, optional parity and stop bit(s). It sits directly downstream of the TX FIFO and drives the device pin.

## Interface

Parameters:
- `DATA_WIDTH`, 8: data bits per frame; must match the FIFO `DATA_WIDTH`.
- `CLKS_PER_BIT`, 868: clock cycles per bit period (100 MHz / 115200). Must be ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `tx_en`  in  1: permission to start a new frame. Sampled only in IDLE.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_read_data`  in  `DATA_WIDTH`: FIFO `read_data`, valid the cycle after a pop.
- `fifo_read_en`  out  1: pop request to the FIFO; combinational, one cycle wide.
- `tx`  out  1: serial line, idle high, registered.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on the last cycle of the final stop bit.

## Operation

States: IDLE, FETCH, START, DATA, PARITY, STOP.

- **IDLE**
  - `tx`=1.
  - `fifo_read_en` = `!rst && tx_en && !fifo_empty`.
  - If `fifo_read_en` is high, go to FETCH; otherwise stay in IDLE.
- **FETCH**: one cycle. Latch `fifo_read_data` into the shift register, compute parity, clear the baud counter, go to START.
- **START**: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
- **DATA**
  - `tx` = `shift[0]` for `CLKS_PER_BIT` cycles per bit; shift right after each bit.
  - After bit `DATA_WIDTH-1`, go to PARITY if `PARITY`≠0, otherwise to STOP.
- **PARITY**
  - `tx` = XOR of the data bits when `PARITY`=1 (even); its inverse when `PARITY`=2 (odd).
  - Lasts `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP**
  - `tx`=1 for `STOP_BITS*CLKS_PER_BIT` cycles.
  - `done`=1 on the final cycle, then go to IDLE.

Counters and arithmetic:
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT-1` and wraps at the terminal count.
- Bit index width is `$clog2(DATA_WIDTH)`. The stop-bit counter is 1 bit.
- No counter ever overflows its width.

Boundary conditions:
- **FIFO empty in IDLE**: no pop; `tx` stays 1 indefinitely.
- **`tx_en` deasserted mid-frame**: the current frame completes; no new pop occurs.
- **`fifo_empty` changes mid-frame**: ignored.
- **Reset mid-frame**: on the next edge, state=IDLE, `tx`=1, `busy`=0, `done`=0, counters=0. The partial frame is abandoned. `fifo_read_en`=0 while `rst`=1.
- **Back-to-back frames**: after `done`, IDLE may pop on the next cycle. The minimum idle-high gap between frames is exactly 2 cycles (IDLE, FETCH).
- The FIFO is never popped while empty; the `!fifo_empty` qualification is mandatory.

## Timing

- **Reset values**: `tx`=1, `busy`=0, `done`=0, `fifo_read_en`=0.
- **Pop to line activity** (pop in cycle N):
  - FETCH in N+1.
  - `tx` falls at the edge ending N+1, so it is low from cycle N+2.
- **Frame length** in cycles, from first START cycle to `done` inclusive: `(1 + DATA_WIDTH + (PARITY≠0) + STOP_BITS) * CLKS_PER_BIT`.
- **`busy`** is high from N+1 through the `done` cycle.
- **Throughput**: one frame every frame length + 2 cycles.

## Structure

- **Package `uart_pkg`**:
  - `tx_state_e` enum (IDLE, FETCH, START, DATA, PARITY, STOP).
  - `parity_e` enum (`PAR_NONE`=0, `PAR_EVEN`=1, `PAR_ODD`=2).
  - Default `CLKS_PER_BIT` localparam.
- **Sub-module `uart_baud_cnt`**:
  - Parameter `CLKS_PER_BIT`.
  - Inputs `clk`, `rst`, `clr`; output `tick`, high on the terminal count.
  - Reused later by the RX stage.
- Output `tx` is driven from a flop only, never combinationally.

## Test plan

Sim parameters for all scenarios: `CLKS_PER_BIT`=4, `DATA_WIDTH`=8.

1. **Single frame**, FIFO holds 0x55, `tx_en`=1, `PARITY`=0 → one `fifo_read_en` pulse. `tx` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `done` 40 cycles after the first START cycle. `busy` drops the cycle after `done`.
2. **Back-to-back**, FIFO holds 0xA3, 0x0F → two pops. `tx` high for exactly 2 cycles between the stop bit of 0xA3 and the start bit of 0x0F. Bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
3. **Parity and stop bits**: `PARITY`=1, 0x07 → parity bit 1. `PARITY`=2, 0x07 → parity bit 0. `STOP_BITS`=2 → stop held 8 cycles, frame 48 cycles.
4. **Empty/enable gating**:
   - `fifo_empty`=1 for 100 cycles → no `fifo_read_en`, `tx`=1, `busy`=0.
   - `tx_en`=0 with data present → no pop.
   - Dropping `tx_en` mid-frame → frame completes, no second pop.
5. **Reset mid-frame**: assert `rst` during DATA bit 3 for 1 cycle → next cycle `tx`=1, `busy`=0. A fresh 0x3C frame afterwards is bit-exact.
6. **Integration with the FIFO**: `count_fifo` depth 4, write 4 bytes 0x11..0x44 → all four serialized in order. `fifo_empty` rises after the 4th pop; no pop while empty.
